audio_tone_serializer: RTL and testbench

//  Consumer of the volume controller's amplitude bounds. Generates a square-wave tone
//  (period set by note_div) swinging between volume_min and volume_max, and serializes it
//  as 16-bit left-justified stereo audio (mono on both channels) to the Pmod audio DAC.

---
 rtl/audio_pkg.sv | 12 +
 rtl/audio_tone_serializer_if.sv | 32 +++
 rtl/audio_tone_serializer_tone_gen.sv | 43 ++++
 rtl/audio_tone_serializer.sv | 76 +++++++
 tb/tb_audio_tone_serializer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared constants for the tone serializer
// Frame counter width, which counter bits become the audio clocks, the slot and
// frame boundary counts, and the silent sample value.
package audio_pkg;
  localparam int          FRAME_CNT_W = 9;
  localparam int          SCK_BIT     = 3;
  localparam int          MCLK_BIT    = 1;
  localparam int          LRCK_BIT    = 8;
  localparam logic [8:0]  SLOT_END    = 9'd255;
  localparam logic [8:0]  FRAME_END   = 9'd511;
  localparam logic [15:0] SILENCE     = 16'h0000;
endpackage

// File: rtl/audio_tone_serializer_if.sv
// rtl/audio_tone_serializer_if.sv - control inputs and DAC pins of the tone serializer
// Ports (signals):
//   note_div, volume_max, volume_min, mute : tone control, driven by master
//   audio_mclk, audio_lrck, audio_sck      : DAC clocks, driven by slave
//   audio_sdin, sample_strobe              : serial data and frame-start pulse
// master = control/board side, slave = the serializer.
interface audio_tone_serializer_if #(
  parameter int SAMPLE_W = 16,
  parameter int DIV_W    = 22
);
  import audio_pkg::*;

  logic [DIV_W-1:0]    note_div;
  logic [SAMPLE_W-1:0] volume_max;
  logic [SAMPLE_W-1:0] volume_min;
  logic                mute;
  logic                audio_mclk;
  logic                audio_lrck;
  logic                audio_sck;
  logic                audio_sdin;
  logic                sample_strobe;

  modport master (
    output note_div, volume_max, volume_min, mute,
    input  audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_strobe
  );

  modport slave (
    input  note_div, volume_max, volume_min, mute,
    output audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_strobe
  );
endinterface

// File: rtl/audio_tone_serializer_tone_gen.sv
// rtl/audio_tone_serializer_tone_gen.sv - square-wave phase generator
// Ports:
//   clk, rst   : system clock, async active-high reset
//   note_div   : half-period in clk cycles, 0 holds the generator idle at level 0
//   tone_level : current square-wave phase (1 = high phase)
module tone_gen #(
  parameter int DIV_W = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] note_div,
  output logic             tone_level
);
  import audio_pkg::*;

  logic [DIV_W-1:0] tone_cnt_q, tone_cnt_d;
  logic             tone_level_q, tone_level_d;

  always_comb begin
    tone_cnt_d   = tone_cnt_q + 1'b1;
    tone_level_d = tone_level_q;
    if (note_div == '0) begin
      tone_cnt_d   = '0;
      tone_level_d = 1'b0;
    end else if (tone_cnt_q >= note_div - 1'b1) begin
      // >= so that shrinking note_div below the running count toggles at once
      tone_cnt_d   = '0;
      tone_level_d = ~tone_level_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tone_cnt_q   <= '0;
      tone_level_q <= 1'b0;
    end else begin
      tone_cnt_q   <= tone_cnt_d;
      tone_level_q <= tone_level_d;
    end
  end

  assign tone_level = tone_level_q;
endmodule

// File: rtl/audio_tone_serializer.sv
// rtl/audio_tone_serializer.sv - square-wave tone to left-justified stereo DAC stream
// Ports:
//   clk, rst : 100 MHz system clock, async active-high reset
//   bus      : slave side of audio_tone_serializer_if (tone controls in,
//              mclk/lrck/sck/sdin/sample_strobe out)
// A free-running 9-bit counter defines a 512-clk frame; the clocks are taken
// straight from its bits. The sample is chosen once per frame and sent MSB
// first in both slots.
module audio_tone_serializer #(
  parameter int SAMPLE_W = 16,
  parameter int DIV_W    = 22
) (
  input  logic                    clk,
  input  logic                    rst,
  audio_tone_serializer_if.slave  bus
);
  import audio_pkg::*;

  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
  logic [SAMPLE_W-1:0]    frame_sample_q, frame_sample_d;
  logic [SAMPLE_W-1:0]    shift_q, shift_d;
  logic                   sdin_q, sdin_d;
  logic [SAMPLE_W-1:0]    next_sample;
  logic                   tone_level;

  tone_gen #(.DIV_W(DIV_W)) u_tone (
    .clk        (clk),
    .rst        (rst),
    .note_div   (bus.note_div),
    .tone_level (tone_level)
  );

  always_comb begin
    cnt_d          = cnt_q + 1'b1;
    frame_sample_d = frame_sample_q;
    shift_d        = shift_q;
    sdin_d         = sdin_q;
    next_sample    = (bus.mute || bus.note_div == '0) ? SAMPLE_W'(SILENCE)
                   : (tone_level ? bus.volume_max : bus.volume_min);
    if (cnt_q == FRAME_END) begin
      // inputs are only looked at here, so a frame never changes mid-flight
      frame_sample_d = next_sample;
      shift_d        = next_sample;
      sdin_d         = next_sample[SAMPLE_W-1];
    end else if (cnt_q == SLOT_END) begin
      // right slot repeats the same word
      shift_d = frame_sample_q;
      sdin_d  = frame_sample_q[SAMPLE_W-1];
    end else if (cnt_q[SCK_BIT:0] == '1) begin
      // last clk of an sck period: next bit appears as sck falls
      shift_d = shift_q << 1;
      sdin_d  = shift_q[SAMPLE_W-2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      frame_sample_q <= '0;
      shift_q        <= '0;
      sdin_q         <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      frame_sample_q <= frame_sample_d;
      shift_q        <= shift_d;
      sdin_q         <= sdin_d;
    end
  end

  assign bus.audio_mclk    = cnt_q[MCLK_BIT];
  assign bus.audio_sck     = cnt_q[SCK_BIT];
  assign bus.audio_lrck    = cnt_q[LRCK_BIT];
  assign bus.audio_sdin    = sdin_q;
  // gated by rst so the pulse stays low while the counter is held at 0
  assign bus.sample_strobe = (cnt_q == '0) && !rst;
endmodule

// File: tb/tb_audio_tone_serializer.sv
// tb/tb_audio_tone_serializer.sv - self-checking bench for audio_tone_serializer
module tb_audio_tone_serializer;
  import audio_pkg::*;

  localparam int SW = 16;
  localparam int DW = 22;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  audio_tone_serializer_if #(.SAMPLE_W(SW), .DIV_W(DW)) bus ();

  audio_tone_serializer #(.SAMPLE_W(SW), .DIV_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: clk edges since reset, tone phase from the toggle rule,
  // and a queue of words expected on the wire, one per frame.
  longint     t;
  longint     base;
  logic       lvl_m;
  bit         active;
  logic [15:0] exp_q[$];

  always @(posedge clk) begin
    if (rst) begin
      t = 0; base = 0; lvl_m = 1'b0; active = 1'b0;
      exp_q.delete();
      exp_q.push_back(16'h0000);
    end else begin
      if (t % 512 == 511)
        exp_q.push_back((bus.mute || bus.note_div == 0) ? 16'h0000
                        : (lvl_m ? bus.volume_max : bus.volume_min));
      if (bus.note_div == 0) begin
        lvl_m = 1'b0; base = t + 1;
      end else if (t - base >= longint'(bus.note_div) - 1) begin
        lvl_m = ~lvl_m; base = t + 1;
      end
      t++;
      active = 1'b1;
    end
  end

  // Monitor: checks clocks against the frame position and decodes sdin at the
  // middle of every bit cell.
  int          mp;
  int          clk_bad = 0;
  int          tone_bad = 0;
  logic [15:0] wl, wr, last_left, last_right;

  always @(negedge clk) begin
    if (rst) begin
      last_left = 16'hDEAD; last_right = 16'hDEAD;
    end else if (active) begin
      mp = int'(t % 512);
      if (bus.audio_mclk !== mp[1] || bus.audio_sck !== mp[3] ||
          bus.audio_lrck !== mp[8] || bus.sample_strobe !== (mp == 0))
        clk_bad++;
      if (dut.u_tone.tone_level_q !== lvl_m) tone_bad++;
      if (mp % 16 == 8) begin
        if (mp < 256) wl[15 - mp / 16] = bus.audio_sdin;
        else          wr[15 - (mp - 256) / 16] = bus.audio_sdin;
      end
      if (mp == 248) begin
        last_left = wl;
        if (exp_q.size() == 0) check("left_queue_empty", 0, 1);
        else check("left_word", wl, exp_q[0]);
      end
      if (mp == 504) begin
        last_right = wr;
        if (exp_q.size() == 0) check("right_queue_empty", 0, 1);
        else check("right_word", wr, exp_q.pop_front());
      end
      if (mp == 511) begin
        check("clock_pins", clk_bad, 0);
        check("tone_level", tone_bad, 0);
        clk_bad = 0; tone_bad = 0;
      end
    end
  end

  typedef struct {
    logic [21:0] nd;
    logic [15:0] vmax;
    logic [15:0] vmin;
    logic        mute;
    logic [15:0] exp_word;
  } vec_t;

  vec_t tbl[6];

  task automatic set_in(input logic [21:0] nd, input logic [15:0] vmax,
                        input logic [15:0] vmin, input logic m);
    bus.note_div = nd; bus.volume_max = vmax; bus.volume_min = vmin; bus.mute = m;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_pos(input int p);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 600 && !hit; i++) begin
      @(negedge clk);
      if (int'(t % 512) == p) hit = 1'b1;
    end
    if (!hit) check("wait_pos_timeout", 0, 1);
  endtask

  task automatic lrck_rise(input string name);
    int k;
    k = 0;
    for (int i = 1; i <= 600 && k == 0; i++) begin
      @(negedge clk);
      if (bus.audio_lrck) k = i;
    end
    check(name, k, 256);
  endtask

  task automatic tone_period(input int exp_p);
    logic l0;
    int   n;
    l0 = dut.u_tone.tone_level_q;
    for (int i = 0; i < 3 * exp_p && dut.u_tone.tone_level_q == l0; i++) @(negedge clk);
    l0 = dut.u_tone.tone_level_q;
    n = 0;
    for (int i = 1; i <= 3 * exp_p && n == 0; i++) begin
      @(negedge clk);
      if (dut.u_tone.tone_level_q != l0) n = i;
    end
    check("tone_period", n, exp_p);
  endtask

  initial begin
    tbl[0] = '{22'd0,       16'h1234, 16'h5678, 1'b0, 16'h0000};
    tbl[1] = '{22'd1000,    16'h0600, 16'hFA00, 1'b1, 16'h0000};
    tbl[2] = '{22'h3FFFFF,  16'h7FFF, 16'h8001, 1'b0, 16'h8001};
    tbl[3] = '{22'd511,     16'h1111, 16'h2222, 1'b0, 16'h1111};
    tbl[4] = '{22'd512,     16'h1111, 16'h2222, 1'b0, 16'h2222};
    tbl[5] = '{22'd1,       16'h1357, 16'h2468, 1'b0, 16'h1357};

    // reset and clock startup
    set_in(22'd0, 16'h0000, 16'h0000, 1'b0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    #1 check("rst_outputs", {bus.audio_mclk, bus.audio_lrck, bus.audio_sck,
                             bus.audio_sdin, bus.sample_strobe}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("strobe_after_release", bus.sample_strobe, 1);
    lrck_rise("lrck_first_rise");
    repeat (800) @(negedge clk);

    // table: second frame after reset for fixed configurations
    foreach (tbl[i]) begin
      @(negedge clk);
      rst = 1'b1;
      set_in(tbl[i].nd, tbl[i].vmax, tbl[i].vmin, tbl[i].mute);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (1017) @(negedge clk);
      check("tbl_left", last_left, tbl[i].exp_word);
      check("tbl_right", last_right, tbl[i].exp_word);
    end

    // tone
    @(negedge clk);
    rst = 1'b1;
    set_in(22'd1000, 16'h0600, 16'hFA00, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tone_period(1000);

    // mute raised mid-frame, then released
    wait_pos(100);
    bus.mute = 1'b1;
    repeat (1100) @(negedge clk);
    check("mute_word", last_left, 16'h0000);
    bus.mute = 1'b0;
    repeat (1100) @(negedge clk);

    // silence
    bus.note_div = 22'd0;
    repeat (1030) @(negedge clk);
    wait_pos(505);
    check("silence_left", last_left, 16'h0000);
    check("silence_right", last_right, 16'h0000);
    check("silence_level", dut.u_tone.tone_level_q, 0);

    // divider shrink
    @(negedge clk);
    rst = 1'b1;
    set_in(22'd50000, 16'h0100, 16'hFF00, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4000) @(negedge clk);
    bus.note_div = 22'd100;
    @(negedge clk);
    check("shrink_toggle", dut.u_tone.tone_level_q, 1);
    repeat (99) @(negedge clk);
    check("shrink_hold", dut.u_tone.tone_level_q, 1);
    @(negedge clk);
    check("shrink_period", dut.u_tone.tone_level_q, 0);

    // reset mid-frame
    bus.note_div = 22'd1000;
    wait_pos(300);
    rst = 1'b1;
    #1 check("async_rst_outputs", {bus.audio_mclk, bus.audio_lrck, bus.audio_sck,
                                   bus.audio_sdin, bus.sample_strobe}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("strobe_after_rerelease", bus.sample_strobe, 1);
    lrck_rise("lrck_rise_after_rst");
    repeat (1000) @(negedge clk);

    // random controls, changed at arbitrary points in the frame
    for (int it = 0; it < 15; it++) begin
      set_in(($urandom % 5 == 0) ? 22'd0 : 22'($urandom_range(1, 1500)),
             16'($urandom), 16'($urandom), ($urandom % 4 == 0));
      repeat ($urandom_range(300, 1200)) @(negedge clk);
    end
    repeat (1100) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
